// File: rtl/seq_divider.sv
// Sequential signed 32-bit restoring divider, one quotient bit per clock.
// Quotient truncates toward zero; remainder takes the sign of the dividend.
module seq_divider (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic [31:0] i_dividend,
    input  logic [31:0] i_divisor,
    output logic        o_busy,
    output logic        o_done,
    output logic [31:0] o_quotient,
    output logic [31:0] o_remainder,
    output logic        o_dbz
);

    typedef enum logic [1:0] {StIdle, StDiv, StFix, StDone} state_e;

    state_e      state;
    logic        sign_a;
    logic        sign_b;
    logic [31:0] quo;
    logic [31:0] div_m;
    logic [31:0] dividend_orig;
    // Partial remainder; the restoring step keeps it below div_m, so bit 32 is always zero.
    logic [31:0] rem;
    logic [5:0]  count;

    logic [31:0] abs_dividend;
    logic [31:0] abs_divisor;
    logic [32:0] rem_shift;
    logic [32:0] trial;
    logic [31:0] quo_signed;
    logic [31:0] rem_signed;

    always_comb begin
        abs_dividend = i_dividend[31] ? (~i_dividend + 32'd1) : i_dividend;
        abs_divisor  = i_divisor[31]  ? (~i_divisor + 32'd1)  : i_divisor;
        rem_shift    = {rem, quo[31]};
        trial        = rem_shift - {1'b0, div_m};
        quo_signed   = (sign_a ^ sign_b) ? (~quo + 32'd1) : quo;
        rem_signed   = sign_a ? (~rem + 32'd1) : rem;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state         <= StIdle;
            sign_a        <= 1'b0;
            sign_b        <= 1'b0;
            quo           <= '0;
            div_m         <= '0;
            dividend_orig <= '0;
            rem           <= '0;
            count         <= '0;
            o_busy        <= 1'b0;
            o_done        <= 1'b0;
            o_quotient    <= '0;
            o_remainder   <= '0;
            o_dbz         <= 1'b0;
        end else begin
            case (state)
                StIdle: begin
                    o_done <= 1'b0;
                    if (i_start) begin
                        sign_a        <= i_dividend[31];
                        sign_b        <= i_divisor[31];
                        quo           <= abs_dividend;
                        div_m         <= abs_divisor;
                        dividend_orig <= i_dividend;
                        rem           <= '0;
                        count         <= '0;
                        o_busy        <= 1'b1;
                        state         <= StDiv;
                    end
                end
                StDiv: begin
                    if (!trial[32]) begin
                        rem <= trial[31:0];
                        quo <= {quo[30:0], 1'b1};
                    end else begin
                        rem <= rem_shift[31:0];
                        quo <= {quo[30:0], 1'b0};
                    end
                    count <= count + 6'd1;
                    if (count == 6'd31) begin
                        state <= StFix;
                    end
                end
                StFix: begin
                    if (div_m == 32'd0) begin
                        o_quotient  <= 32'hFFFF_FFFF;
                        o_remainder <= dividend_orig;
                        o_dbz       <= 1'b1;
                    end else begin
                        o_quotient  <= quo_signed;
                        o_remainder <= rem_signed;
                        o_dbz       <= 1'b0;
                    end
                    // Busy falls in the same cycle the done pulse rises.
                    o_busy <= 1'b0;
                    o_done <= 1'b1;
                    state  <= StDone;
                end
                StDone: begin
                    o_done <= 1'b0;
                    state  <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: doc/seq_divider.md
# seq_divider

Sequential signed 32-bit integer divider using restoring shift-and-subtract, one quotient bit per clock. It is the inverse datapath of the team's shift-and-accumulate multiplier and sits beside it in the arithmetic unit. Operands are captured on a start handshake, and results are held until the next accepted start. Quotient truncates toward zero, and the remainder takes the sign of the dividend.

## Interface
- No parameters. Width is fixed at 32.
- i_clk  input  1  sole clock, rising edge.
- i_rst  input  1  reset, synchronous and active-high.
- i_start  input  1  request; sampled only while o_busy=0.
- i_dividend  input  32  signed dividend, two's complement.
- i_divisor  input  32  signed divisor, two's complement.
- o_busy  output  1  high from the cycle after an accepted start until o_done.
- o_done  output  1  one-cycle pulse; results valid from this cycle.
- o_quotient  output  32  signed quotient, held until the next accepted start.
- o_remainder  output  32  signed remainder, held likewise.
- o_dbz  output  1  divide-by-zero flag for the last operation, held likewise.

## Operation
- **State machine:** IDLE, DIV, FIX, DONE.
- **IDLE:**
  - If i_start=1, latch sign_a = i_dividend[31], sign_b = i_divisor[31], |dividend| into the 32-bit Q register and |divisor| into the 32-bit M register.
  - Clear the 33-bit partial remainder R and the 6-bit count.
  - Go to DIV.
  - Magnitude is ~x+1 when negative; |0x80000000| = 0x80000000 as unsigned.
- **DIV (exactly 32 cycles):**
  - Each cycle: {R,Q} <<= 1, then T = R - {1'b0,M} (33-bit).
  - If T[32]=0, R <= T and Q[0] <= 1; otherwise R is unchanged and Q[0] <= 0.
  - Count increments each cycle; after the 32nd cycle go to FIX.
- **FIX (1 cycle):**
  - If divisor was zero: o_quotient = 0xFFFFFFFF, o_remainder = original dividend, o_dbz = 1.
  - Otherwise: o_quotient = (sign_a^sign_b) ? -Q : Q, and o_remainder = sign_a ? -R[31:0] : R[31:0], o_dbz = 0.
  - Go to DONE.
- **DONE (1 cycle):** o_done = 1, then go to IDLE.
- **Overflow:** 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000 and remainder 0, with no flag. This is the natural wrap and is required behaviour.
- **Busy start:** i_start while o_busy=1 or during DONE is ignored; no queueing.
- **Input stability:** operand inputs are don't-care except in the accepting cycle. Changing them mid-operation has no effect.

## Timing
- **Reset values:**
  - State IDLE.
  - o_busy = 0, o_done = 0, o_dbz = 0.
  - o_quotient = 0, o_remainder = 0.
  - R, Q, M and count = 0.
- **Reset priority:** reset has priority in every state. Reset mid-DIV aborts with no o_done and clears the outputs.
- **Latency:**
  - Start accepted at edge E0.
  - DIV occupies E1..E32; FIX result is registered at E33.
  - o_done is high in the cycle following E33 (34 cycles after acceptance).
  - o_busy is high from after E0 through E33 and drops together with the o_done pulse.
- **Back-to-back:** a new start is accepted on the first IDLE cycle, one cycle after o_done. Maximum throughput is one result per 35 cycles.
- **Output stability:** o_quotient, o_remainder and o_dbz change only at the FIX edge or on reset.
- **No combinational paths:** none from inputs to outputs; all outputs are registered.

## Test plan
- 100 / 7 (0x64 / 0x7) -> quotient 0x0000000E, remainder 0x00000002, o_dbz 0; o_done exactly 34 cycles after the start edge.
- -100 / 7 (0xFFFFFF9C / 0x7) -> quotient 0xFFFFFFF2 (-14), remainder 0xFFFFFFFE (-2).
- 100 / -7 -> quotient 0xFFFFFFF2, remainder 0x00000002.
- -100 / -7 -> quotient 0x0000000E, remainder 0xFFFFFFFE.
- 5 / 0 -> quotient 0xFFFFFFFF, remainder 0x00000005, o_dbz 1, same latency.
- 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0; then 0x80000000 / 1 -> quotient 0x80000000, remainder 0.
- Pulse i_start with new operands at cycle 10 of DIV -> ignored; the original result is produced.
- Assert i_rst at cycle 20 of DIV -> all outputs 0 next cycle, no o_done.
- A following start computes correctly.
- Random 10k signed pairs are checked against a $signed reference model.
